clockster_gen: RTL and testbench
================================

CLOCKSTER_GEN -- requirements
Module: clockster_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 6: master phase counter width, minimum 4.
REQ-002 SHALL have parameter INIT_DELAY, default 3: clocks from reset release until strobes start.
REQ-003 SHALL have parameter PHACC_WIDTH, default 32: NCO accumulator width.
REQ-004 SHALL have parameter PHACC_DELTA, default 253896634: NCO increment loaded at reset.
REQ-005 SHALL have port clk, input, 1: single master clock, 24 MHz nominal; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port turbo, input, 1: request for double-rate CPU strobe.
REQ-008 SHALL have port hold_req, input, 1: request to freeze CPU strobes.
REQ-009 SHALL have port hold_ack, output, 1: CPU strobes frozen.
REQ-010 SHALL have port delta_wr, input, 1: load strobe for the NCO increment.
REQ-011 SHALL have port delta_in, input, PHACC_WIDTH: new NCO increment.
REQ-012 SHALL have ports ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5, each output, 1: registered enables and slice flags.
REQ-013 SHALL have port ce_nco, output, 1: one-cycle strobe on NCO carry.
REQ-014 SHALL have port nco_msb, output, 1: accumulator MSB, a square wave.
REQ-015 SHALL have port ready, output, 1: high once INIT completes.

Function
REQ-016 SHALL implement FSM states INIT, RUN and HOLD.
- INIT -> RUN after INIT_DELAY clocks.
- RUN -> HOLD, and HOLD -> RUN, only at a slot boundary (ctr[2:0]==7), per REQ-021 and REQ-022.
REQ-017 SHALL, in INIT, hold ctr at 0, drive every output 0 and hold the accumulator; ready SHALL rise on the edge entering RUN.
REQ-018 SHALL, in RUN and HOLD, per edge, register outputs from the current ctr value k, then set ctr to (k+1) mod 2^CNT_WIDTH. Output functions:
- ce12 = k[0]
- ce6 = k[1]&k[0]
- ce3v = k[2]&k[1]&~k[0]
- video_slice = ~k[2]
- pipe_ab = k[CNT_WIDTH-1]
REQ-019 SHALL generate ce3 as follows:
- Normal mode: ce3 = k[2]&~k[1]&k[0], once per 8 clocks.
- Turbo mode: ce3 = ~k[1]&k[0], once per 4 clocks.
- In both modes: ce1m5 = k[3]&k[2]&~k[1]&k[0].
REQ-020 SHALL sample turbo into the active mode only on edges where ctr[2:0]==7, so a mode change never yields two ce3 pulses less than 4 clocks apart.
REQ-021 SHALL enter HOLD from RUN on the edge where hold_req==1 and ctr[2:0]==7, and set hold_ack=1 on that same edge; hold_ack therefore asserts at most 8 clocks after hold_req.
REQ-022 SHALL, while in HOLD, force ce3 and ce1m5 to 0.
- ce12, ce6, ce3v, video_slice, pipe_ab and ctr SHALL continue unchanged.
- Return to RUN and clear hold_ack on the edge where hold_req==0 and ctr[2:0]==7.
REQ-023 SHALL, in RUN and HOLD, update the accumulator each clock as acc <= (acc + delta) mod 2^PHACC_WIDTH.
- ce_nco SHALL be registered from the carry out of bit PHACC_WIDTH-1.
- nco_msb SHALL equal acc[PHACC_WIDTH-1].
REQ-024 SHALL, on delta_wr, load delta_in into delta; the new value SHALL apply from the following addition. If delta_wr coincides with an addition, that addition and its carry SHALL use the old delta.
REQ-025 SHALL, with delta==0, hold acc constant and keep ce_nco at 0.

Reset
REQ-026 SHALL, when reset is high at an edge, set state=INIT, init counter=0, ctr=0, acc=0, delta=PHACC_DELTA, turbo mode=0 and hold_ack=0, and drive every output 0, regardless of the current state.
REQ-027 SHALL, when reset asserts mid-HOLD or mid-turbo, drop hold_ack and the turbo mode on the next edge; after release the block SHALL repeat the full INIT_DELAY sequence.

Verification
REQ-028 SHALL cover: release reset, defaults -> ready high 3 clocks later; ce12 every 2 clocks, ce6 every 4, ce3 every 8, ce1m5 every 16, pipe_ab period 64; first RUN output has video_slice=1 with all strobes 0.
REQ-029 SHALL cover: turbo=1 asserted with ctr[2:0]==2 -> unchanged until the next ctr==7 boundary, then ce3 every 4 clocks; no two ce3 closer than 4 clocks; turbo=0 -> return to 8-clock spacing after the next boundary.
REQ-030 SHALL cover: hold_req=1 at a random cycle -> hold_ack within 1..8 clocks and zero ce3/ce1m5 while hold_ack=1, with ce12, ce3v and video_slice cadence unbroken; hold_req=0 -> hold_ack clears at the next boundary and ce3 resumes in phase.
REQ-031 SHALL cover: delta_wr with delta_in=2^30 -> ce_nco every 4 clocks and nco_msb period 4; then delta_in=2^31 -> every 2 clocks from the following addition; delta_in=0 -> ce_nco stays 0.
REQ-032 SHALL cover: default delta for 1,000,000 RUN clocks -> 59115 ±1 ce_nco pulses.
REQ-033 SHALL cover: reset pulsed during HOLD with turbo active -> next edge all outputs 0, hold_ack 0, delta back to 253896634, ready low for 3 clocks after release.

Source files
------------

// File: rtl/clockster_gen.sv
// clockster_gen: master-clock enable generator with turbo CPU strobe, slot-aligned hold and an NCO.
module clockster_gen #(
  parameter int CNT_WIDTH = 6,
  parameter int INIT_DELAY = 3,
  parameter int PHACC_WIDTH = 32,
  parameter logic [PHACC_WIDTH-1:0] PHACC_DELTA = 253896634
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   turbo,
  input  logic                   hold_req,
  output logic                   hold_ack,
  input  logic                   delta_wr,
  input  logic [PHACC_WIDTH-1:0] delta_in,
  output logic                   ce12,
  output logic                   ce6,
  output logic                   ce3,
  output logic                   ce3v,
  output logic                   video_slice,
  output logic                   pipe_ab,
  output logic                   ce1m5,
  output logic                   ce_nco,
  output logic                   nco_msb,
  output logic                   ready
);
  localparam int IW = INIT_DELAY > 1 ? $clog2(INIT_DELAY) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_DELAY - 1);
  typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] init_cnt;
  logic [CNT_WIDTH-1:0] ctr;
  logic [PHACC_WIDTH-1:0] acc, delta;
  logic turbo_mode;
  logic boundary;
  assign boundary = &ctr[2:0];
  assign nco_msb = acc[PHACC_WIDTH-1];
  // mode changes only at slot boundaries so CPU strobes never bunch up
  always_comb begin
    state_n = state;
    state_n = state == INIT ? (init_cnt == INIT_LAST ? RUN : INIT)
            : !boundary ? state
            : hold_req ? HOLD : RUN;
  end
  always_ff @(posedge clk)
    state <= reset ? INIT : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      init_cnt <= '0;
      ctr <= '0;
      acc <= '0;
      delta <= PHACC_DELTA;
      turbo_mode <= 1'b0;
      hold_ack <= 1'b0;
      ready <= 1'b0;
      {ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5, ce_nco} <= '0;
    end else begin
      if (delta_wr) delta <= delta_in;
      hold_ack <= state_n == HOLD;
      ready <= state_n != INIT;
      if (state == INIT) begin
        init_cnt <= init_cnt + IW'(1);
      end else begin
        ctr <= ctr + CNT_WIDTH'(1);
        if (boundary) turbo_mode <= turbo;
        {ce_nco, acc} <= {1'b0, acc} + {1'b0, delta};
        ce12 <= ctr[0];
        ce6 <= ctr[1] && ctr[0];
        ce3v <= ctr[2] && ctr[1] && !ctr[0];
        video_slice <= !ctr[2];
        pipe_ab <= ctr[CNT_WIDTH-1];
        ce3 <= state == RUN && (turbo_mode ? !ctr[1] && ctr[0] : ctr[2] && !ctr[1] && ctr[0]);
        ce1m5 <= state == RUN && ctr[3] && ctr[2] && !ctr[1] && ctr[0];
      end
    end
endmodule

// File: tb/tb_clockster_gen.sv
// tb_clockster_gen: directed bench for clockster_gen with cadence counters sampled after each edge.
module tb_clockster_gen;
  logic clk = 0, reset = 1, turbo = 0, hold_req = 0, delta_wr = 0;
  logic [31:0] delta_in = '0;
  logic hold_ack, ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5, ce_nco, nco_msb, ready;
  wire [10:0] outs = {ready, hold_ack, nco_msb, ce_nco, ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5};
  int checks = 0, errors = 0, cnt = 0, n;
  int cyc = 0, last3, min3, max3, lastn, minn, maxn;
  int n_ce3, n_nco, n_ce12, n_ce6, n_ce1m5, n_ce3v, n_pipe, n_vs, n_msb, n_hack;
  localparam longint NLONG = 40000;
  clockster_gen dut (
    .clk(clk), .reset(reset), .turbo(turbo), .hold_req(hold_req), .hold_ack(hold_ack),
    .delta_wr(delta_wr), .delta_in(delta_in), .ce12(ce12), .ce6(ce6), .ce3(ce3), .ce3v(ce3v),
    .video_slice(video_slice), .pipe_ab(pipe_ab), .ce1m5(ce1m5), .ce_nco(ce_nco),
    .nco_msb(nco_msb), .ready(ready)
  );
  always #5 clk = ~clk;
  // pulse counters and gap extremes, sampled 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (ce3) begin
      if (last3 >= 0) begin
        min3 = (cyc - last3 < min3) ? cyc - last3 : min3;
        max3 = (cyc - last3 > max3) ? cyc - last3 : max3;
      end
      last3 = cyc;
      n_ce3++;
    end
    if (ce_nco) begin
      if (lastn >= 0) begin
        minn = (cyc - lastn < minn) ? cyc - lastn : minn;
        maxn = (cyc - lastn > maxn) ? cyc - lastn : maxn;
      end
      lastn = cyc;
      n_nco++;
    end
    n_ce12 += int'(ce12);
    n_ce6 += int'(ce6);
    n_ce1m5 += int'(ce1m5);
    n_ce3v += int'(ce3v);
    n_pipe += int'(pipe_ab);
    n_vs += int'(video_slice);
    n_msb += int'(nco_msb);
    n_hack += int'(hold_ack);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cnt++;
  endtask
  task automatic clr();
    last3 = -1; min3 = 1000; max3 = 0; lastn = -1; minn = 1000; maxn = 0;
    n_ce3 = 0; n_nco = 0; n_ce12 = 0; n_ce6 = 0; n_ce1m5 = 0; n_ce3v = 0;
    n_pipe = 0; n_vs = 0; n_msb = 0; n_hack = 0;
  endtask
  task automatic release_and_wait();
    reset = 0;
    tick(); chk("ready_e1", ready, 0);
    tick(); chk("ready_e2", ready, 0);
    tick(); chk("ready_e3", ready, 1);
    cnt = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clr();
    @(negedge clk);
    repeat (2) tick();
    chk("reset_outs", outs, 0);
    release_and_wait();
    chk("entry_outs", outs, 11'h400);
    clr();
    tick();
    chk("first_run", outs, 11'h404);
    repeat (63) tick();
    chk("ce12_n", n_ce12, 32);
    chk("ce6_n", n_ce6, 16);
    chk("ce3_n", n_ce3, 8);
    chk("ce3_min", min3, 8);
    chk("ce3_max", max3, 8);
    chk("ce1m5_n", n_ce1m5, 4);
    chk("ce3v_n", n_ce3v, 8);
    chk("pipe_hi", n_pipe, 32);
    chk("vs_hi", n_vs, 32);
    while (cnt % 8 != 2) tick();
    turbo = 1;
    clr();
    repeat (4) tick();
    chk("turbo_pre", n_ce3, 1);
    repeat (32) tick();
    chk("turbo_n", n_ce3, 9);
    chk("turbo_min", min3, 4);
    chk("turbo_max", max3, 4);
    while (cnt % 8 != 0) tick();
    turbo = 0;
    clr();
    repeat (16) tick();
    chk("untrb_n", n_ce3, 3);
    chk("untrb_min", min3, 4);
    chk("untrb_max", max3, 8);
    clr();
    repeat (32) tick();
    chk("normal_n", n_ce3, 4);
    chk("normal_min", min3, 8);
    while (cnt % 8 != 3) tick();
    hold_req = 1;
    n = 0;
    do begin tick(); n++; end while (!hold_ack && n < 12);
    chk("hold_lat", n, 5);
    clr();
    repeat (32) tick();
    chk("hold_ce3", n_ce3, 0);
    chk("hold_ce1m5", n_ce1m5, 0);
    chk("hold_ce12", n_ce12, 16);
    chk("hold_ce3v", n_ce3v, 4);
    chk("hold_vs", n_vs, 16);
    chk("hold_ack_n", n_hack, 32);
    hold_req = 0;
    n = 0;
    do begin tick(); n++; end while (hold_ack && n < 12);
    chk("unhold_lat", n, 8);
    clr();
    repeat (5) tick();
    chk("resume_pre", n_ce3, 0);
    tick();
    chk("resume_ce3", ce3, 1);
    delta_wr = 1; delta_in = 32'h4000_0000;
    tick();
    delta_wr = 0;
    clr();
    repeat (32) tick();
    chk("nco30_n", n_nco, 8);
    chk("nco30_min", minn, 4);
    chk("nco30_max", maxn, 4);
    chk("nco30_msb", n_msb, 16);
    delta_wr = 1; delta_in = 32'h8000_0000;
    tick();
    delta_wr = 0;
    clr();
    repeat (32) tick();
    chk("nco31_n", n_nco, 16);
    chk("nco31_min", minn, 2);
    chk("nco31_max", maxn, 2);
    delta_wr = 1; delta_in = 0;
    tick();
    delta_wr = 0;
    clr();
    repeat (32) tick();
    chk("nco0_n", n_nco, 0);
    chk("nco0_msb", n_msb == 0 || n_msb == 32, 1);
    turbo = 1;
    hold_req = 1;
    n = 0;
    do begin tick(); n++; end while (!hold_ack && n < 12);
    chk("hold_lat2", n <= 8 && hold_ack, 1);
    repeat (8) tick();
    reset = 1;
    tick();
    chk("reset_hold", outs, 0);
    turbo = 0;
    hold_req = 0;
    release_and_wait();
    clr();
    repeat (16) tick();
    chk("post_rst_ce3", n_ce3, 2);
    chk("post_rst_ack", n_hack, 0);
    repeat (NLONG - 16) tick();
    chk("nco_long", n_nco, (NLONG * 64'd253896634) >> 32);
    reset = 1;
    tick();
    reset = 0;
    delta_wr = 1; delta_in = 32'h8000_0000;
    tick();
    delta_wr = 0;
    repeat (2) tick();
    chk("init_ready", ready, 1);
    tick();
    chk("acc_step1", {nco_msb, ce_nco}, 2'b10);
    delta_wr = 1; delta_in = 0;
    tick();
    delta_wr = 0;
    chk("acc_old_delta", {nco_msb, ce_nco}, 2'b01);
    tick();
    chk("acc_new_delta", {nco_msb, ce_nco}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
